mem_rmw_ctrl: RTL and testbench
===============================

// Module: mem_rmw_ctrl
// PURPOSE
//  Sequencer between the core's load/store request and a 1-cycle-latency synchronous data RAM.
//  Reads the target word, presents it to the LSU byte/half/word lane logic, and writes back the merged word.
//  Lane extraction is done by the LSU. Sub-word stores become read-modify-write; word stores skip the read.
//  Detects misaligned or illegal accesses and reports them without touching memory.
// PARAMETERS
//  WIDTH   32  data width; lane logic assumes 32
//  ADDR_W  32  byte-address width; RAM word address is ADDR_W-2 bits
// PORTS
//  clk            in   1         rising-edge clock
//  rst_n          in   1         asynchronous, active-low reset
//  req_valid      in   1         core presents a request
//  req_ready      out  1         1 only in IDLE; request accepted on req_valid&&req_ready
//  req_addr       in   ADDR_W    byte address
//  req_we         in   1         1=store, 0=load
//  req_bhw        in   2         0=byte 1=half 2=word 3=illegal
//  req_sign       in   1         sign-extend loads
//  req_wdata      in   WIDTH     store data (low lanes significant)
//  resp_valid     out  1         one-cycle pulse, transaction complete
//  resp_rdata     out  WIDTH     load result, held until next load response
//  resp_err       out  1         valid with resp_valid; misaligned/illegal
//  lsu_addr       out  ADDR_W    registered request address
//  lsu_data       out  WIDTH     registered RAM word (word_q)
//  lsu_wdata      out  WIDTH     registered store data
//  lsu_bhw        out  2         registered size
//  lsu_sign       out  1         registered sign flag
//  lsu_memwrite   out  1         registered req_we
//  lsu_readdata   in   WIDTH     LSU extracted load value
//  lsu_writedata  in   WIDTH     LSU merged store word
//  mem_en         out  1         RAM access strobe
//  mem_we         out  1         RAM write enable (only with mem_en)
//  mem_addr       out  ADDR_W-2  word address = lsu_addr[ADDR_W-1:2]
//  mem_wdata      out  WIDTH     = lsu_writedata
//  mem_rdata      in   WIDTH     valid the cycle after mem_en&&!mem_we
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE.
//   All request/word registers, resp_rdata and resp_err are 0.
//   mem_en, mem_we and resp_valid are 0 immediately.
//   Reset mid-transaction abandons it: no write, no response.
//  FSM states: IDLE, RD, CAP, MRG, WR, RSP. mem_en, mem_we and resp_valid are decoded from the state register only.
//  IDLE: on accept, register the request.
//   Misaligned is bhw==3, bhw==1&&addr[0], or bhw==2&&addr[1:0]!=0.
//   If misaligned: set resp_err=1 and go to RSP.
//   Else if word store: go to WR.
//   Otherwise: go to RD.
//  RD: mem_en=1, mem_we=0 -> CAP.
//  CAP: word_q<=mem_rdata.
//   Store -> WR.
//   Load -> MRG.
//  MRG: resp_rdata<=lsu_readdata, resp_err<=0 -> RSP.
//  WR: mem_en=1, mem_we=1, mem_wdata=lsu_writedata -> RSP.
//   For a word store, lsu_writedata equals the store data.
//  RSP: resp_valid=1 -> IDLE. There is no backpressure on the response.
//  Latency from the accept edge to the resp_valid cycle:
//   load = 4 cycles
//   sub-word store = 4 cycles
//   word store = 2 cycles
//   error = 1 cycle
//  req_valid outside IDLE is ignored; the core must hold the request until req_ready.
//  resp_err clears on the next accepted request.
//  A store never updates resp_rdata.
//  At most one RAM access per cycle. The RMW is atomic: no other request is accepted until RSP completes.
// STRUCTURE
//  Shared pkg: state encoding localparams and BHW codes (BYTE=0, HALF=1, WORD=2).
//  Sub-module: the existing LSU, instantiated inside (u_lsu) driven by the lsu_* registers.
//   lsu_* ports stay exported for debug.
//  Otherwise a single always_ff for state/registers plus one combinational decode.
// TESTING
//  RAM word 0x0=0x8899AABB; load bhw=0 sign=1 addr 0x2 -> resp_rdata=0xFFFFFF99, resp_valid 4 cycles after accept.
//  Same word; store bhw=1 addr 0x2 wdata 0x1234 -> one RD, then WR of 0x1234AABB; 4-cycle latency.
//  Store bhw=2 addr 0x8 wdata 0xDEADBEEF -> no read; single write of 0xDEADBEEF to word 2; resp after 2 cycles.
//  Load bhw=1 addr 0x3; then bhw=3 -> resp_err=1 after 1 cycle; mem_en never asserted; resp_rdata unchanged.
//  Drop rst_n during WR -> mem_we falls asynchronously, no resp_valid; next request completes normally.
//  Back-to-back: req_valid held high -> second accept only the cycle after RSP; req_ready=0 in RD..RSP.

Source files
------------

// File: rtl/mem_rmw_ctrl_pkg.sv
// Shared definitions for the load/store read-modify-write sequencer:
// access-size codes, FSM state encoding and the alignment rule.
package mem_rmw_ctrl_pkg;

    localparam logic [1:0] BHW_BYTE = 2'd0;
    localparam logic [1:0] BHW_HALF = 2'd1;
    localparam logic [1:0] BHW_WORD = 2'd2;
    localparam logic [1:0] BHW_ILL  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_MRG  = 3'd3,
        ST_WR   = 3'd4,
        ST_RSP  = 3'd5
    } state_e;

    // Size code 3 is never legal; halves need an even address, words a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] bhw, input logic [1:0] addr_lo);
        logic bad;
        case (bhw)
            BHW_BYTE: bad = 1'b0;
            BHW_HALF: bad = addr_lo[0];
            BHW_WORD: bad = (addr_lo != 2'b00);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_rmw_ctrl_if.sv
// Core-side request/response bundle of the read-modify-write sequencer.
interface mem_rmw_ctrl_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
);
    // A request transfers on the rising edge where req_valid && req_ready; the
    // master holds all req_* stable until then. resp_valid is a one-cycle pulse
    // with no backpressure; resp_rdata/resp_err are meaningful while it is high.
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [1:0]        req_bhw;
    logic              req_sign;
    logic [WIDTH-1:0]  req_wdata;
    logic              resp_valid;
    logic [WIDTH-1:0]  resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_addr, req_we, req_bhw, req_sign, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_bhw, req_sign, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_rmw_ctrl_lsu.sv
// Byte/half/word lane logic: extracts a load value from a RAM word and
// merges store data into it. Lane positions assume a 32-bit word.
module mem_rmw_ctrl_lsu
    import mem_rmw_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       addr_lo_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [1:0]       bhw_i,
    input  logic             sign_i,
    output logic [WIDTH-1:0] readdata_o,
    output logic [WIDTH-1:0] writedata_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_sh = {addr_lo_i, 3'b000};
    assign half_sh = {addr_lo_i[1], 4'b0000};
    assign byte_v  = word_i[byte_sh +: 8];
    assign half_v  = word_i[half_sh +: 16];

    always_comb begin
        readdata_o  = word_i;
        writedata_o = word_i;
        case (bhw_i)
            BHW_BYTE: begin
                readdata_o = {{(WIDTH-8){sign_i & byte_v[7]}}, byte_v};
                writedata_o[byte_sh +: 8] = wdata_i[7:0];
            end
            BHW_HALF: begin
                readdata_o = {{(WIDTH-16){sign_i & half_v[15]}}, half_v};
                writedata_o[half_sh +: 16] = wdata_i[15:0];
            end
            BHW_WORD: begin
                readdata_o  = word_i;
                writedata_o = wdata_i;
            end
            default: begin
                readdata_o  = word_i;
                writedata_o = word_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// Sequencer between a core load/store request and a 1-cycle-latency RAM:
// sub-word stores become read-modify-write, word stores write directly.
module mem_rmw_ctrl
    import mem_rmw_ctrl_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_rmw_ctrl_if.slave     bus,
    output logic [ADDR_W-1:0] lsu_addr_o,
    output logic [WIDTH-1:0]  lsu_data_o,
    output logic [WIDTH-1:0]  lsu_wdata_o,
    output logic [1:0]        lsu_bhw_o,
    output logic              lsu_sign_o,
    output logic              lsu_memwrite_o,
    output logic [WIDTH-1:0]  lsu_readdata_o,
    output logic [WIDTH-1:0]  lsu_writedata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [WIDTH-1:0]  mem_wdata_o,
    input  logic [WIDTH-1:0]  mem_rdata_i,
    output state_e            state_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [WIDTH-1:0]  word_q;
    logic [WIDTH-1:0]  wdata_q;
    logic [1:0]        bhw_q;
    logic              sign_q;
    logic              we_q;
    logic [WIDTH-1:0]  rdata_q;
    logic              err_q;
    logic              accept;
    logic              misaligned;
    logic [WIDTH-1:0]  lsu_readdata;
    logic [WIDTH-1:0]  lsu_writedata;

    assign accept     = bus.req_valid && (state_q == ST_IDLE);
    assign misaligned = is_misaligned(bus.req_bhw, bus.req_addr[1:0]);

    mem_rmw_ctrl_lsu #(
        .WIDTH (WIDTH)
    ) u_lsu (
        .addr_lo_i   (addr_q[1:0]),
        .word_i      (word_q),
        .wdata_i     (wdata_q),
        .bhw_i       (bhw_q),
        .sign_i      (sign_q),
        .readdata_o  (lsu_readdata),
        .writedata_o (lsu_writedata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            bhw_q   <= BHW_BYTE;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                bhw_q   <= bus.req_bhw;
                sign_q  <= bus.req_sign;
                we_q    <= bus.req_we;
                err_q   <= misaligned;
            end
            if (state_q == ST_CAP) begin
                word_q <= mem_rdata_i;
            end
            // Only loads reach MRG, so stores leave the last load result intact.
            if (state_q == ST_MRG) begin
                rdata_q <= lsu_readdata;
                err_q   <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (misaligned) begin
                        state_d = ST_RSP;
                    end else if (bus.req_we && (bus.req_bhw == BHW_WORD)) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD:   state_d = ST_CAP;
            ST_CAP:  state_d = we_q ? ST_WR : ST_MRG;
            ST_MRG:  state_d = ST_RSP;
            ST_WR:   state_d = ST_RSP;
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes come from the state register alone so reset drops them at once.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        mem_en_o       = 1'b0;
        mem_we_o       = 1'b0;
        case (state_q)
            ST_IDLE: bus.req_ready = 1'b1;
            ST_RD:   mem_en_o = 1'b1;
            ST_WR: begin
                mem_en_o = 1'b1;
                mem_we_o = 1'b1;
            end
            ST_RSP:  bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.resp_rdata  = rdata_q;
    assign bus.resp_err    = err_q;
    assign lsu_addr_o      = addr_q;
    assign lsu_data_o      = word_q;
    assign lsu_wdata_o     = wdata_q;
    assign lsu_bhw_o       = bhw_q;
    assign lsu_sign_o      = sign_q;
    assign lsu_memwrite_o  = we_q;
    assign lsu_readdata_o  = lsu_readdata;
    assign lsu_writedata_o = lsu_writedata;
    assign mem_addr_o      = addr_q[ADDR_W-1:2];
    assign mem_wdata_o     = lsu_writedata;
    assign state_o         = state_q;

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Bench for mem_rmw_ctrl: behavioural RAM, transaction-level reference model,
// directed cases with literal expectations, then randomized traffic.
module tb_mem_rmw_ctrl;
    import mem_rmw_ctrl_pkg::*;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 32;
    localparam int NWORDS = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_rmw_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    logic [31:0] lsu_addr, lsu_data, lsu_wdata, lsu_readdata, lsu_writedata;
    logic [1:0]  lsu_bhw;
    logic        lsu_sign, lsu_memwrite;
    logic        mem_en, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] ram_rdata;
    state_e      dbg_state;

    mem_rmw_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .lsu_addr_o      (lsu_addr),
        .lsu_data_o      (lsu_data),
        .lsu_wdata_o     (lsu_wdata),
        .lsu_bhw_o       (lsu_bhw),
        .lsu_sign_o      (lsu_sign),
        .lsu_memwrite_o  (lsu_memwrite),
        .lsu_readdata_o  (lsu_readdata),
        .lsu_writedata_o (lsu_writedata),
        .mem_en_o        (mem_en),
        .mem_we_o        (mem_we),
        .mem_addr_o      (mem_addr),
        .mem_wdata_o     (mem_wdata),
        .mem_rdata_i     (ram_rdata),
        .state_o         (dbg_state)
    );

    // ---------------- behavioural synchronous RAM ----------------
    logic [31:0] ram [NWORDS];
    logic        preload_en = 1'b0;
    logic [3:0]  preload_idx = '0;
    logic [31:0] preload_val = '0;

    always @(posedge clk) begin
        if (preload_en) ram[preload_idx] <= preload_val;
        else if (mem_en) begin
            if (mem_we) ram[mem_addr[3:0]] <= mem_wdata;
            else        ram_rdata <= ram[mem_addr[3:0]];
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          lat;
        logic        err;
        logic        we;
        logic        is_load;
        logic [31:0] rdata;
        int          n_rd;
        int          n_wr;
        logic [31:0] new_word;
        logic [31:0] waddr;
        int          acc_cyc;
    } txn_t;

    // Transaction-level expectation from the access rules: size in bytes,
    // alignment by modulo, lanes by shifting and masking.
    function automatic txn_t model_txn(input logic [31:0] addr, input logic we, input logic [1:0] bhw,
                                       input logic sign, input logic [31:0] wdata, input logic [31:0] w);
        txn_t t;
        int nb, sh;
        logic [31:0] mask, v;
        nb = 1 << bhw;
        t.err = (bhw == 2'd3) || ((addr % nb) != 0);
        t.we = we;
        t.is_load = !we;
        t.waddr = addr >> 2;
        t.acc_cyc = 0;
        t.rdata = '0;
        t.new_word = w;
        if (t.err) begin
            t.lat = 1; t.n_rd = 0; t.n_wr = 0;
        end else begin
            sh = 8 * int'(addr[1:0]);
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
            v = (w >> sh) & mask;
            if (sign && nb < 4 && v[8*nb-1]) v = v | ~mask;
            t.rdata = v;
            t.new_word = (w & ~(mask << sh)) | ((wdata & mask) << sh);
            if (we && nb == 4) begin
                t.lat = 2; t.n_rd = 0; t.n_wr = 1;
            end else begin
                t.lat = 4; t.n_rd = 1; t.n_wr = we ? 1 : 0;
            end
        end
        return t;
    endfunction

    // ---------------- scoreboard / compare process ----------------
    txn_t        exp_q[$];
    txn_t        mon_t;
    logic [31:0] ref_mem [NWORDS];
    logic [31:0] exp_rdata = '0;
    bit          busy = 0;
    int          cyc = 0;
    int          acc_count = 0, resp_count = 0;
    int          cur_rd = 0, cur_wr = 0;
    logic [31:0] cur_wr_val = '0, cur_wr_addr = '0;
    int          last_lat = 0, last_n_rd = 0, last_n_wr = 0;
    int          last_acc_cyc = 0, last_resp_cyc = 0;
    logic [31:0] last_rdata = '0, last_wr_val = '0, last_wr_addr = '0;
    logic        last_err = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (preload_en) ref_mem[preload_idx] = preload_val;
        if (!rst_n) begin
            chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
            chk("rst_mem_en", 32'(mem_en), 32'd0);
            busy = 0;
            exp_q.delete();
            exp_rdata = '0;
            cur_rd = 0;
            cur_wr = 0;
        end else begin
            chk("req_ready", 32'(bus.req_ready), 32'(!busy));
            if (mem_en) begin
                if (exp_q.size() == 0) chk("mem_en_idle", 32'(mem_en), 32'd0);
                else chk("mem_addr", {2'b00, mem_addr}, exp_q[0].waddr);
                if (mem_we) begin
                    cur_wr++;
                    cur_wr_val = mem_wdata;
                    cur_wr_addr = {2'b00, mem_addr};
                end else begin
                    cur_rd++;
                end
            end
            if (bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("resp_spurious", 32'(bus.resp_valid), 32'd0);
                end else begin
                    mon_t = exp_q.pop_front();
                    if (mon_t.is_load && !mon_t.err) exp_rdata = mon_t.rdata;
                    chk("latency", cyc - mon_t.acc_cyc, mon_t.lat);
                    chk("resp_err", 32'(bus.resp_err), 32'(mon_t.err));
                    chk("resp_rdata", bus.resp_rdata, exp_rdata);
                    chk("ram_reads", cur_rd, mon_t.n_rd);
                    chk("ram_writes", cur_wr, mon_t.n_wr);
                    if (mon_t.n_wr == 1) chk("ram_wdata", cur_wr_val, mon_t.new_word);
                    if (mon_t.we && !mon_t.err) ref_mem[mon_t.waddr[3:0]] = mon_t.new_word;
                    last_lat = cyc - mon_t.acc_cyc;
                    last_rdata = bus.resp_rdata;
                    last_err = bus.resp_err;
                    last_n_rd = cur_rd;
                    last_n_wr = cur_wr;
                    last_wr_val = cur_wr_val;
                    last_wr_addr = cur_wr_addr;
                    last_resp_cyc = cyc;
                    resp_count++;
                end
                busy = 0;
                cur_rd = 0;
                cur_wr = 0;
            end
            if (bus.req_valid && bus.req_ready) begin
                mon_t = model_txn(bus.req_addr, bus.req_we, bus.req_bhw, bus.req_sign,
                                  bus.req_wdata, ref_mem[bus.req_addr[5:2]]);
                mon_t.acc_cyc = cyc;
                exp_q.push_back(mon_t);
                busy = 1;
                acc_count++;
                last_acc_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input int idx, input logic [31:0] val);
        preload_idx = idx[3:0];
        preload_val = val;
        preload_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [31:0] addr, input logic we, input logic [1:0] bhw,
                            input logic sign, input logic [31:0] wdata, input bit hold);
        int a0;
        bit ok;
        a0 = acc_count;
        ok = 0;
        bus.req_addr = addr;
        bus.req_we = we;
        bus.req_bhw = bhw;
        bus.req_sign = sign;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (acc_count != a0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int r0;
        bit ok;
        r0 = resp_count;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (resp_count != r0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input logic [31:0] addr, input logic we, input logic [1:0] bhw,
                       input logic sign, input logic [31:0] wdata);
        send_req(addr, we, bhw, sign, wdata, 1'b0);
        wait_resp();
    endtask

    task automatic check_reset_state();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid_now", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_mem_en_now", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
        chk("rst_lsu_addr", lsu_addr, 32'd0);
        chk("rst_lsu_data", lsu_data, 32'd0);
        chk("rst_lsu_wdata", lsu_wdata, 32'd0);
        chk("rst_lsu_bhw", 32'(lsu_bhw), 32'd0);
        chk("rst_lsu_sign", 32'(lsu_sign), 32'd0);
        chk("rst_lsu_memwrite", 32'(lsu_memwrite), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time %0t exceeded, expected finish earlier", $time);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int r;
        int r0;
        int a_resp;
        bit ok;
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.req_we = 1'b0;
        bus.req_bhw = 2'd0;
        bus.req_sign = 1'b0;
        bus.req_wdata = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < NWORDS; i++) preload(i, (i == 0) ? 32'h8899_AABB : $urandom());
        preload_en = 1'b0;
        check_reset_state();
        rst_n = 1'b1;

        // signed byte load from the known word
        run(32'h2, 1'b0, BHW_BYTE, 1'b1, 32'h0);
        chk("d_ldb_rdata", last_rdata, 32'hFFFF_FF99);
        chk("d_ldb_lat", last_lat, 32'd4);
        chk("d_ldb_err", 32'(last_err), 32'd0);

        // half store: read once, write merged word
        run(32'h2, 1'b1, BHW_HALF, 1'b0, 32'h1234);
        chk("d_sth_lat", last_lat, 32'd4);
        chk("d_sth_reads", last_n_rd, 32'd1);
        chk("d_sth_writes", last_n_wr, 32'd1);
        chk("d_sth_wval", last_wr_val, 32'h1234_AABB);

        // word store: no read
        run(32'h8, 1'b1, BHW_WORD, 1'b0, 32'hDEAD_BEEF);
        chk("d_stw_lat", last_lat, 32'd2);
        chk("d_stw_reads", last_n_rd, 32'd0);
        chk("d_stw_writes", last_n_wr, 32'd1);
        chk("d_stw_wval", last_wr_val, 32'hDEAD_BEEF);
        chk("d_stw_waddr", last_wr_addr, 32'd2);

        // misaligned half, then illegal size
        run(32'h3, 1'b0, BHW_HALF, 1'b0, 32'h0);
        chk("d_mis_err", 32'(last_err), 32'd1);
        chk("d_mis_lat", last_lat, 32'd1);
        chk("d_mis_mem", last_n_rd + last_n_wr, 32'd0);
        chk("d_mis_rdata", last_rdata, 32'hFFFF_FF99);
        run(32'h0, 1'b0, BHW_ILL, 1'b0, 32'h0);
        chk("d_ill_err", 32'(last_err), 32'd1);
        chk("d_ill_lat", last_lat, 32'd1);
        chk("d_ill_rdata", last_rdata, 32'hFFFF_FF99);

        // error clears on the next request
        run(32'h0, 1'b0, BHW_WORD, 1'b0, 32'h0);
        chk("d_ldw_rdata", last_rdata, 32'h1234_AABB);
        chk("d_ldw_err", 32'(last_err), 32'd0);

        // back-to-back with req_valid held
        send_req(32'h1, 1'b0, BHW_BYTE, 1'b0, 32'h0, 1'b1);
        bus.req_addr = 32'h8;
        bus.req_bhw = BHW_WORD;
        wait_resp();
        chk("d_b2b_a_rdata", last_rdata, 32'h0000_00AA);
        a_resp = last_resp_cyc;
        send_req(32'h8, 1'b0, BHW_WORD, 1'b0, 32'h0, 1'b0);
        chk("d_b2b_gap", last_acc_cyc - a_resp, 32'd1);
        wait_resp();
        chk("d_b2b_b_rdata", last_rdata, 32'hDEAD_BEEF);

        // reset during WR abandons the store
        run(32'h10, 1'b1, BHW_WORD, 1'b0, 32'h1122_3344);
        send_req(32'h10, 1'b1, BHW_WORD, 1'b0, 32'hCAFE_BABE, 1'b0);
        ok = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (mem_we) begin
                ok = 1;
                break;
            end
        end
        chk("d_wr_seen", 32'(ok), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("d_async_mem_we", 32'(mem_we), 32'd0);
        check_reset_state();
        r0 = resp_count;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("d_abort_no_resp", resp_count, r0);
        run(32'h10, 1'b0, BHW_WORD, 1'b0, 32'h0);
        chk("d_abort_no_write", last_rdata, 32'h1122_3344);

        // randomized traffic against the model
        for (int n = 0; n < 200; n++) begin
            logic [1:0] bhw;
            r = $urandom_range(0, 9);
            bhw = (r < 3) ? BHW_BYTE : (r < 6) ? BHW_HALF : (r < 9) ? BHW_WORD : BHW_ILL;
            run(32'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), bhw,
                1'($urandom_range(0, 1)), $urandom());
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
